jump_target_unit: RTL and testbench
===================================

# jump_target_unit

Registered program-counter sequencer for the processor front end, the next generation of the combinational jump-label mux. It holds a run-time-writable label table of `2**LABEL_W` jump targets, selects the next PC each cycle from sequential, register-indirect, label, call or return sources, and keeps a small hardware return stack. It sits between instruction decode (which supplies `op`/`label`/`reg_target`) and instruction fetch (which consumes `pc`).

## Interface
- `PC_W`, 16, PC and target width
- `LABEL_W`, 4, label index width; table depth = 2**LABEL_W
- `STACK_DEPTH`, 4, return-stack entries (≥1)
- `RESET_PC`, 0, PC value after reset

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `op`  in  3  000 SEQ, 001 JREG, 010 JLBL, 011 CALL, 100 RET, 101–111 treated as SEQ
- `label`  in  LABEL_W  table index for JLBL/CALL
- `reg_target`  in  PC_W  target for JREG
- `stall`  in  1  hold PC; `op` ignored
- `wr_en`  in  1  write label table
- `wr_idx`  in  LABEL_W  entry to write
- `wr_addr`  in  PC_W  target value written
- `clr_err`  in  1  clear sticky error flags
- `pc`  out  PC_W  current PC (registered)
- `sp`  out  clog2(STACK_DEPTH+1)  return-stack occupancy
- `bad_label`  out  1  sticky: JLBL/CALL to unwritten entry
- `ovf`  out  1  sticky: CALL with stack full
- `unf`  out  1  sticky: RET with stack empty

## Operation
- Clock and reset: one clock; reset synchronous, active-low.
- Reset (`rst_n`=0 at edge): `pc`=RESET_PC, `sp`=0, all table valid bits cleared, entries 0, `bad_label`=`ovf`=`unf`=0. Reset overrides all other inputs.
- Next PC, `stall`=0:
  - SEQ: pc+1, modulo 2**PC_W (0xFFFF→0x0000 at PC_W=16)
  - JREG: reg_target
  - JLBL: table[label] if valid, else pc+1 and set `bad_label`
  - CALL: as JLBL for the target; pushes pc+1 (wrapped) when the target is valid and `sp`<STACK_DEPTH. Stack full: no push, jump still taken, set `ovf`. Invalid label: no push, pc+1, set `bad_label`.
  - RET: `sp`>0 → pop, pc = top entry; `sp`=0 → pc+1, set `unf`
- `stall`=1: pc, stack and flags unchanged; table write still performed.
- Table write: `wr_en`=1 writes `wr_addr` to entry `wr_idx` and sets its valid bit. Independent of `stall`.
- Write/read collision: when `wr_en`=1 and `wr_idx`==`label` in the same cycle as JLBL/CALL, the jump uses `wr_addr` (write-through bypass) and the entry counts as valid.
- Flags are sticky until `clr_err`=1. If `clr_err` and a new error event occur in the same cycle, the flag ends up set.
- Stack is LIFO; entries above `sp` are don't-care.

## Timing
- All outputs are registered. Inputs sampled at a rising edge take effect on `pc`/`sp`/flags immediately after that edge (1-cycle latency, one decision per cycle).
- No combinational path from any input to any output.
- Table write becomes visible to a jump issued on the same edge (bypass) or any later edge.
- Back-to-back CALL/RET on consecutive cycles are supported with no bubble.

## Test plan
- Reset then 3 cycles SEQ -> pc 0,1,2,3; `sp`=0; all flags 0. Assert `rst_n`=0 during a CALL -> next pc=0, `sp`=0.
- Write entry 6 = 8, then JLBL label 6 -> pc=8. JLBL label 9 (never written) from pc=8 -> pc=9, `bad_label`=1; `clr_err` -> 0.
- Same-cycle write idx 3=0x0042 with JLBL label 3 -> pc=0x0042.
- From pc=0x0010, CALL label 1 (=22) -> pc=22, `sp`=1; RET -> pc=0x0011, `sp`=0; RET again -> pc=0x0012, `unf`=1.
- 5 nested CALLs, STACK_DEPTH=4 -> `sp` stays 4 and `ovf`=1 after the 5th, which still jumps; 4 RETs return the first four pushed addresses in reverse order.
- JREG 0xFFFF then SEQ -> pc=0x0000. With `stall`=1 and op=JREG 0x1234 -> pc held, while a concurrent table write still lands.

Source files
------------

// File: rtl/jump_target_unit.sv
// Next-PC sequencer: label table with write-through bypass, register/label jumps and a return stack.
// One decision per cycle and all outputs registered (1-cycle latency); stall holds pc/stack/flags but still takes table writes.
module jump_target_unit #(
  parameter int              PC_W        = 16,
  parameter int              LABEL_W     = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [2:0]                         op,
  input  logic [LABEL_W-1:0]                 label,
  input  logic [PC_W-1:0]                    reg_target,
  input  logic                               stall,
  input  logic                               wr_en,
  input  logic [LABEL_W-1:0]                 wr_idx,
  input  logic [PC_W-1:0]                    wr_addr,
  input  logic                               clr_err,
  output logic [PC_W-1:0]                    pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               bad_label,
  output logic                               ovf,
  output logic                               unf
);

  localparam int DEPTH = 2 ** LABEL_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_JREG = 3'b001;
  localparam logic [2:0] OP_JLBL = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [PC_W-1:0]  tbl [DEPTH];
  logic [DEPTH-1:0] tbl_valid;
  logic [PC_W-1:0]  stk [STACK_DEPTH];

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_next;
  logic [SP_W-1:0]  sp_next;
  logic [PC_W-1:0]  lbl_target;
  logic             lbl_ok;
  logic             bypass;
  logic             stack_full;
  logic             push;
  logic             set_bad;
  logic             set_ovf;
  logic             set_unf;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;

  assign pc_inc     = pc + PC_W'(1);
  // A write landing on the entry being jumped through is forwarded this cycle.
  assign bypass     = wr_en && (wr_idx == label);
  assign lbl_target = bypass ? wr_addr : tbl[label];
  assign lbl_ok     = bypass || tbl_valid[label];
  assign stack_full = (sp == SP_W'(STACK_DEPTH));
  assign push_idx   = IDX_W'(sp);
  assign pop_idx    = IDX_W'(sp - SP_W'(1));

  always_comb begin
    pc_next = pc_inc;
    sp_next = sp;
    push    = 1'b0;
    set_bad = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else begin
      case (op)
        OP_JREG: pc_next = reg_target;
        OP_JLBL: begin
          if (lbl_ok) pc_next = lbl_target;
          else        set_bad = 1'b1;
        end
        OP_CALL: begin
          if (!lbl_ok) begin
            set_bad = 1'b1;
          end else begin
            pc_next = lbl_target;
            if (stack_full) begin
              set_ovf = 1'b1;
            end else begin
              push    = 1'b1;
              sp_next = sp + SP_W'(1);
            end
          end
        end
        OP_RET: begin
          if (sp != '0) begin
            pc_next = stk[pop_idx];
            sp_next = sp - SP_W'(1);
          end else begin
            set_unf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      sp        <= '0;
      tbl_valid <= '0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      bad_label <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (wr_en) begin
        tbl[wr_idx]       <= wr_addr;
        tbl_valid[wr_idx] <= 1'b1;
      end
      pc <= pc_next;
      sp <= sp_next;
      // A clear and a new event in the same cycle leave the flag set.
      if (!stall) begin
        bad_label <= (bad_label & ~clr_err) | set_bad;
        ovf       <= (ovf & ~clr_err) | set_ovf;
        unf       <= (unf & ~clr_err) | set_unf;
      end
    end
  end

  // Entries above sp are don't-care, so the stack storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) stk[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_jump_target_unit.sv
// Directed test-plan steps followed by randomized cycles, all checked against a queue/array reference model.
module tb_jump_target_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [3:0]  label = '0;
  logic [15:0] reg_target = '0;
  logic        stall = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [15:0] wr_addr = '0;
  logic        clr_err = 1'b0;
  logic [15:0] pc;
  logic [2:0]  sp;
  logic        bad_label, ovf, unf;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stack [$];
  logic [15:0] m_tbl [16];
  bit          m_vld [16];
  bit          m_bad, m_ovf, m_unf;

  jump_target_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .label(label), .reg_target(reg_target),
    .stall(stall), .wr_en(wr_en), .wr_idx(wr_idx), .wr_addr(wr_addr), .clr_err(clr_err),
    .pc(pc), .sp(sp), .bad_label(bad_label), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one rising edge, evaluated from the inputs currently applied.
  task automatic model_step();
    bit          hit, ok, e_bad, e_ovf, e_unf;
    logic [15:0] tgt, nxt;
    if (!rst_n) begin
      m_pc = 16'h0000;
      m_stack.delete();
      for (int i = 0; i < 16; i++) begin m_tbl[i] = 16'h0; m_vld[i] = 0; end
      m_bad = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    hit = wr_en && (wr_idx == label);
    ok  = hit || m_vld[label];
    tgt = hit ? wr_addr : m_tbl[label];
    e_bad = 0; e_ovf = 0; e_unf = 0;
    if (!stall) begin
      nxt = m_pc + 16'd1;
      if (op == 3'd1) nxt = reg_target;
      else if (op == 3'd2) begin
        if (ok) nxt = tgt; else e_bad = 1;
      end else if (op == 3'd3) begin
        if (!ok) e_bad = 1;
        else begin
          if (m_stack.size() < 4) m_stack.push_back(m_pc + 16'd1);
          else e_ovf = 1;
          nxt = tgt;
        end
      end else if (op == 3'd4) begin
        if (m_stack.size() > 0) nxt = m_stack.pop_back();
        else e_unf = 1;
      end
      m_bad = (clr_err ? 1'b0 : m_bad) | e_bad;
      m_ovf = (clr_err ? 1'b0 : m_ovf) | e_ovf;
      m_unf = (clr_err ? 1'b0 : m_unf) | e_unf;
      m_pc = nxt;
    end
    if (wr_en) begin m_tbl[wr_idx] = wr_addr; m_vld[wr_idx] = 1; end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".sp"}, {13'd0, sp}, 16'(m_stack.size()));
    check({tag, ".bad"}, {15'd0, bad_label}, {15'd0, m_bad});
    check({tag, ".ovf"}, {15'd0, ovf}, {15'd0, m_ovf});
    check({tag, ".unf"}, {15'd0, unf}, {15'd0, m_unf});
  endtask

  task automatic set_in(input logic [2:0] o, input logic [3:0] l, input logic [15:0] rt,
                        input logic we, input logic [3:0] wi, input logic [15:0] wa, input logic ce);
    op = o; label = l; reg_target = rt; wr_en = we; wr_idx = wi; wr_addr = wa; clr_err = ce;
  endtask

  initial begin
    // reset, then sequential counting
    rst_n = 1'b0; set_in(3'd0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
    tick("reset");
    check("reset_pc", pc, 16'h0000);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick("seq");
      check("seq_pc", pc, 16'(i));
    end
    // reset overrides a CALL
    rst_n = 1'b0; set_in(3'd3, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
    tick("rst_call");
    check("rst_call_pc", pc, 16'h0000);
    check("rst_call_sp", {13'd0, sp}, 16'd0);
    rst_n = 1'b1;
    // label write then jump; unwritten label
    set_in(3'd0, 4'd0, 16'h0, 1'b1, 4'd6, 16'h0008, 1'b0); tick("wr6");
    set_in(3'd2, 4'd6, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);     tick("jlbl6");
    check("jlbl6_pc", pc, 16'h0008);
    set_in(3'd2, 4'd9, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);     tick("jlbl9");
    check("jlbl9_pc", pc, 16'h0009);
    check("jlbl9_bad", {15'd0, bad_label}, 16'd1);
    set_in(3'd0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);     tick("clr");
    check("clr_bad", {15'd0, bad_label}, 16'd0);
    // same-cycle write/jump bypass
    set_in(3'd2, 4'd3, 16'h0, 1'b1, 4'd3, 16'h0042, 1'b0);  tick("bypass");
    check("bypass_pc", pc, 16'h0042);
    // call/return, with label 1 written alongside the JREG
    set_in(3'd1, 4'd0, 16'h0010, 1'b1, 4'd1, 16'd22, 1'b0); tick("jreg10");
    set_in(3'd3, 4'd1, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);     tick("call1");
    check("call1_pc", pc, 16'd22);
    check("call1_sp", {13'd0, sp}, 16'd1);
    set_in(3'd4, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);     tick("ret1");
    check("ret1_pc", pc, 16'h0011);
    tick("ret2");
    check("ret2_pc", pc, 16'h0012);
    check("ret2_unf", {15'd0, unf}, 16'd1);
    // fill labels 10..14 with 0x100..0x500 (first cycle also clears flags)
    for (int i = 0; i < 5; i++) begin
      set_in(3'd0, 4'd0, 16'h0, 1'b1, 4'(10 + i), 16'((i + 1) * 256), i == 0);
      tick("fill");
    end
    check("fill_pc", pc, 16'h0017);
    check("fill_unf", {15'd0, unf}, 16'd0);
    // five nested calls against a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      set_in(3'd3, 4'(10 + i), 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      tick("nest");
      check("nest_pc", pc, 16'((i + 1) * 256));
    end
    check("nest_sp", {13'd0, sp}, 16'd4);
    check("nest_ovf", {15'd0, ovf}, 16'd1);
    set_in(3'd4, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
    tick("unnest"); check("unnest_pc3", pc, 16'h0301);
    tick("unnest"); check("unnest_pc2", pc, 16'h0201);
    tick("unnest"); check("unnest_pc1", pc, 16'h0101);
    tick("unnest"); check("unnest_pc0", pc, 16'h0018);
    check("unnest_sp", {13'd0, sp}, 16'd0);
    // wrap, then stall with a concurrent write
    set_in(3'd1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b0); tick("jregff");
    check("jregff_pc", pc, 16'hFFFF);
    set_in(3'd0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);    tick("wrap");
    check("wrap_pc", pc, 16'h0000);
    stall = 1'b1;
    set_in(3'd1, 4'd0, 16'h1234, 1'b1, 4'd7, 16'h0077, 1'b0); tick("stall");
    check("stall_pc", pc, 16'h0000);
    stall = 1'b0;
    set_in(3'd2, 4'd7, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);   tick("after_stall");
    check("after_stall_pc", pc, 16'h0077);
    // randomized cycles
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      stall = ($urandom_range(0, 7) == 0);
      op = 3'($urandom_range(0, 7));
      label = 4'($urandom);
      reg_target = 16'($urandom);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_idx = ($urandom_range(0, 3) == 0) ? label : 4'($urandom);
      wr_addr = 16'($urandom);
      clr_err = !stall && ($urandom_range(0, 9) == 0);
      tick("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
